hd_clkload_gate_ctrl: RTL and testbench
=======================================

// Module: hd_clkload_gate_ctrl
// PURPOSE
//  Clock-enable controller for a gated clock branch with shared clock-load cells.
//  Arbitrates clock demand from NREQ requesters and drives the ICG enable (CEN).
//  Sequences the branch through a wake-up settle, an active phase and an idle
//  hold-off before gating. Sits beside the ICG at the root of each gated branch.
// PARAMETERS
//  NREQ      4    number of requesters (1..16)
//  WAKE_CYC  3    cycles CEN is high before any ACK is granted (>=1)
//  HOLD_CYC  8    idle cycles with no demand before CEN drops (0 = gate at once)
//  CW        4    counter width; must hold max(WAKE_CYC,HOLD_CYC)
//  STAT_W    16   width of GATED_CNT
// PORTS
//  CK         in   1       clock (free-running, ungated side)
//  RN         in   1       reset, asynchronous, active-low
//  REQ        in   NREQ    per-requester clock demand, level
//  FORCE_ON   in   1       test/debug: hold branch clock on; counts as demand
//  CEN        out  1       registered enable to ICG
//  ACK        out  NREQ    per-requester grant: gated clock is stable
//  STATE      out  2       FSM state: 00 OFF, 01 WAKE, 10 ON, 11 HOLD
//  GATED_CNT  out  STAT_W  cycles spent in OFF (see CONFIGURATION)
// BEHAVIOUR
//  Clock and reset: one clock CK; reset RN is asynchronous, active-low.
//  All outputs are registered on CK rising edge.
//  Reset (RN=0, async): STATE=OFF, CEN=0, ACK=0, counters=0, GATED_CNT=0.
//  Reset mid-operation aborts any state immediately; no ACK glitch.
//  demand = |REQ | FORCE_ON (sampled each edge).
//  OFF:  CEN=0, ACK=0. If demand=1 -> WAKE; CEN=1 and ctr=WAKE_CYC-1 on the same edge.
//  WAKE: CEN=1, ACK=0. If ctr!=0, ctr-- and stay in WAKE. If ctr==0 -> ON.
//        Result: exactly WAKE_CYC cycles in WAKE.
//        Demand dropping in WAKE does not abort; the wake completes, then the normal ON rule applies.
//  ON:   CEN=1. ACK[i] <= REQ[i] on each edge (1-cycle latency).
//        ACK also loads REQ on the edge entering ON.
//        If demand=0 and HOLD_CYC>0 -> HOLD, ctr=HOLD_CYC-1, ACK=0.
//        If demand=0 and HOLD_CYC==0 -> OFF, CEN=0, ACK=0.
//  HOLD: CEN=1, ACK=0. If demand=1 -> ON and ACK<=REQ; no re-wake is needed.
//        Else if ctr==0 -> OFF, CEN=0 on that edge.
//        Else ctr--. Result: exactly HOLD_CYC idle cycles in HOLD.
//  Simultaneous events in HOLD: demand returning on the same edge as ctr==0 -> ON wins.
//  Latency, REQ rise in OFF -> ACK: WAKE_CYC+1 edges. In HOLD: 1 edge.
//  Invariant: ACK!=0 implies STATE==ON and CEN==1.
//  Invariant: CEN==0 iff STATE==OFF.
//  ACK is never set for a requester whose REQ was 0 on the previous edge.
//  Counter arithmetic is unsigned CW-bit and never wraps; decrement only when ctr!=0.
// CONFIGURATION
//  HDCGC_STATS_EN defined: GATED_CNT increments on each edge that starts in OFF.
//    It saturates at 2^STAT_W-1 and clears only on reset.
//  Not defined: the GATED_CNT port remains, tied to 0; no counter flops are built.
// TESTING
//  1 Reset: RN=0 mid-ON with REQ=4'b0011 -> same cycle CEN=0, ACK=0, STATE=00.
//    RN release with REQ=0 -> stays OFF.
//  2 Wake: REQ=4'b0001 at edge 0 from OFF -> CEN=1 after edge 1.
//    STATE=01 for 3 cycles; ACK=4'b0001 and STATE=10 after edge 4.
//  3 Hold: drop REQ in ON -> ACK=0 next edge; CEN stays high 8 cycles.
//    CEN=0 and STATE=00 after the 9th edge.
//  4 Re-request: REQ[2]=1 in 5th HOLD cycle -> STATE=10, ACK=4'b0100 next edge; CEN never drops.
//  5 Multi/boundary: REQ=4'b1010 then 4'b1000 in ON -> ACK follows with 1-cycle lag.
//    HOLD_CYC=0 build: REQ drop -> OFF on the next edge.
//  6 Stats (HDCGC_STATS_EN, STAT_W=4): hold OFF for 20 cycles -> GATED_CNT saturates at 15.
//    Non-macro build: GATED_CNT==0 throughout.

Source files
------------

// File: rtl/hd_clkload_gate_ctrl.sv
// hd_clkload_gate_ctrl: ICG enable controller with wake settle, active grant and idle hold-off; HDCGC_STATS_EN adds the OFF-cycle counter
module hd_clkload_gate_ctrl #(
    parameter int NREQ     = 4,
    parameter int WAKE_CYC = 3,
    parameter int HOLD_CYC = 8,
    parameter int CW       = 4,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic              force_on,
    output logic              cen,
    output logic [NREQ-1:0]   ack,
    output logic [1:0]        state,
    output logic [STAT_W-1:0] gated_cnt
);
    typedef enum logic [1:0] {OFF = 2'b00, WAKE = 2'b01, ON = 2'b10, HOLD = 2'b11} state_t;
    localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC > 0 ? HOLD_CYC - 1 : 0);
    state_t st, st_n;
    logic [CW-1:0] ctr, ctr_n;
    logic [NREQ-1:0] ack_n;
    logic demand;
    assign demand = |req | force_on;
    assign state  = st;
    // State, counter and registered outputs; reset aborts any phase at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= OFF;
            ctr <= '0;
            cen <= 1'b0;
            ack <= '0;
        end else begin
            st  <= st_n;
            ctr <= ctr_n;
            cen <= st_n != OFF;
            ack <= ack_n;
        end
    end
    // Next state: grants only ever come from the current REQ on an edge landing in ON
    always_comb begin
        st_n  = st;
        ctr_n = ctr;
        ack_n = '0;
        case (st)
            OFF: begin
                if (demand) begin
                    st_n  = WAKE;
                    ctr_n = WAKE_LD;
                end
            end
            WAKE: begin
                if (ctr != '0) begin
                    ctr_n = ctr - 1'b1;
                end else begin
                    st_n  = ON;
                    ack_n = req;
                end
            end
            ON: begin
                if (demand) begin
                    ack_n = req;
                end else if (HOLD_CYC > 0) begin
                    st_n  = HOLD;
                    ctr_n = HOLD_LD;
                end else begin
                    st_n = OFF;
                end
            end
            default: begin
                if (demand) begin
                    st_n  = ON;
                    ack_n = req;
                end else if (ctr == '0) begin
                    st_n = OFF;
                end else begin
                    ctr_n = ctr - 1'b1;
                end
            end
        endcase
    end
`ifdef HDCGC_STATS_EN
    // Saturating count of edges that start in OFF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gated_cnt <= '0;
        else if (st == OFF && gated_cnt != {STAT_W{1'b1}}) gated_cnt <= gated_cnt + 1'b1;
    end
`else
    assign gated_cnt = '0;
`endif
endmodule

// File: tb/tb_hd_clkload_gate_ctrl.sv
// tb_hd_clkload_gate_ctrl: scoreboard bench for the clock-gate enable controller, plus a HOLD_CYC=0 instance
module tb_hd_clkload_gate_ctrl;
    localparam logic [1:0] S_OFF = 2'b00, S_WAKE = 2'b01, S_ON = 2'b10, S_HOLD = 2'b11;
`ifdef HDCGC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, force_on = 1'b0;
    logic [3:0] req = '0;
    logic cen, cen0;
    logic [3:0] ack, ack0, gcnt, gcnt0;
    logic [1:0] state, state0;
    int n_chk = 0, n_fail = 0;
    logic [6:0] exp_q[$], got_q[$];

    always #5 clk = ~clk;

    hd_clkload_gate_ctrl #(.NREQ(4), .WAKE_CYC(3), .HOLD_CYC(8), .CW(4), .STAT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .force_on(force_on),
        .cen(cen), .ack(ack), .state(state), .gated_cnt(gcnt));
    hd_clkload_gate_ctrl #(.NREQ(4), .WAKE_CYC(3), .HOLD_CYC(0), .CW(4), .STAT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .force_on(force_on),
        .cen(cen0), .ack(ack0), .state(state0), .gated_cnt(gcnt0));

    function automatic logic [6:0] o(input logic [1:0] s, input logic [3:0] a);
        return {s, s != S_OFF, a};
    endfunction

    task automatic drive(input logic [3:0] r, input logic f, input logic [6:0] e);
        exp_q.push_back(e);
        req = r;
        force_on = f;
        @(posedge clk);
        #1;
        got_q.push_back({state, cen, ack});
    endtask

    task automatic test_reset();
        logic [6:0] e, g;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({state, cen, ack} !== 7'd0) begin n_fail++; $display("FAIL reset_init: got %b expected %b", {state, cen, ack}, 7'd0); end
        n_chk++;
        if (gcnt !== 4'd0) begin n_fail++; $display("FAIL reset_gcnt: got %0d expected 0", gcnt); end
        rst_n = 1'b1;
        repeat (3) drive(4'b0011, 1'b0, o(S_WAKE, 4'b0000));
        repeat (2) drive(4'b0011, 1'b0, o(S_ON, 4'b0011));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL reset_wake: got %b expected %b", g, e); end
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({state, cen, ack} !== 7'd0) begin n_fail++; $display("FAIL reset_async: got %b expected %b", {state, cen, ack}, 7'd0); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) drive(4'b0000, 1'b0, o(S_OFF, 4'b0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL reset_release: got %b expected %b", g, e); end
        end
        n_chk++;
        if (gcnt !== (STATS ? 4'd2 : 4'd0)) begin n_fail++; $display("FAIL gcnt_count: got %0d expected %0d", gcnt, STATS ? 2 : 0); end
    endtask

    task automatic test_wake();
        logic [6:0] e, g;
        repeat (3) drive(4'b0001, 1'b0, o(S_WAKE, 4'b0000));
        drive(4'b0001, 1'b0, o(S_ON, 4'b0001));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL wake: got %b expected %b", g, e); end
        end
    endtask

    task automatic test_hold();
        logic [6:0] e, g;
        n_chk++;
        if ({state0, cen0, ack0} !== o(S_ON, 4'b0001)) begin n_fail++; $display("FAIL hold0_on: got %b expected %b", {state0, cen0, ack0}, o(S_ON, 4'b0001)); end
        drive(4'b0000, 1'b0, o(S_HOLD, 4'b0000));
        n_chk++;
        if ({state0, cen0, ack0} !== 7'd0) begin n_fail++; $display("FAIL hold0_off: got %b expected %b", {state0, cen0, ack0}, 7'd0); end
        repeat (7) drive(4'b0000, 1'b0, o(S_HOLD, 4'b0000));
        repeat (2) drive(4'b0000, 1'b0, o(S_OFF, 4'b0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL hold: got %b expected %b", g, e); end
        end
    endtask

    task automatic test_rerequest();
        logic [6:0] e, g;
        repeat (3) drive(4'b0001, 1'b0, o(S_WAKE, 4'b0000));
        drive(4'b0001, 1'b0, o(S_ON, 4'b0001));
        repeat (4) drive(4'b0000, 1'b0, o(S_HOLD, 4'b0000));
        drive(4'b0100, 1'b0, o(S_ON, 4'b0100));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL rerequest: got %b expected %b", g, e); end
        end
    endtask

    task automatic test_multi();
        logic [6:0] e, g;
        drive(4'b1010, 1'b0, o(S_ON, 4'b1010));
        drive(4'b1000, 1'b0, o(S_ON, 4'b1000));
        drive(4'b1000, 1'b0, o(S_ON, 4'b1000));
        drive(4'b0000, 1'b1, o(S_ON, 4'b0000));
        drive(4'b0000, 1'b0, o(S_HOLD, 4'b0000));
        drive(4'b0000, 1'b1, o(S_ON, 4'b0000));
        repeat (8) drive(4'b0000, 1'b0, o(S_HOLD, 4'b0000));
        drive(4'b0000, 1'b0, o(S_OFF, 4'b0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL multi: got %b expected %b", g, e); end
        end
    endtask

    task automatic test_wake_drop();
        logic [6:0] e, g;
        drive(4'b0010, 1'b0, o(S_WAKE, 4'b0000));
        repeat (2) drive(4'b0000, 1'b0, o(S_WAKE, 4'b0000));
        drive(4'b0000, 1'b0, o(S_ON, 4'b0000));
        repeat (8) drive(4'b0000, 1'b0, o(S_HOLD, 4'b0000));
        drive(4'b0000, 1'b0, o(S_OFF, 4'b0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL wake_drop: got %b expected %b", g, e); end
        end
    endtask

    task automatic test_stats();
        logic [6:0] e, g;
        repeat (20) drive(4'b0000, 1'b0, o(S_OFF, 4'b0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL stats_off: got %b expected %b", g, e); end
        end
        n_chk++;
        if (gcnt !== (STATS ? 4'd15 : 4'd0)) begin n_fail++; $display("FAIL gcnt_sat: got %0d expected %0d", gcnt, STATS ? 15 : 0); end
        n_chk++;
        if (gcnt0 !== (STATS ? 4'd15 : 4'd0)) begin n_fail++; $display("FAIL gcnt0_sat: got %0d expected %0d", gcnt0, STATS ? 15 : 0); end
    endtask

    initial begin
        test_reset();
        test_wake();
        test_hold();
        test_rerequest();
        test_multi();
        test_wake_drop();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
